// File: rtl/layer_stream_feeder.sv
// Frame buffer and valid/ready word streamer feeding a layer_M_N_P_T input port.
// Optional macro LAYER_FEEDER_STALL_EN inserts LFSR-driven bubbles before each word.
module layer_stream_feeder #(
  parameter  int M       = 4,
  parameter  int N       = 4,
  parameter  int T       = 16,
  parameter  int NUM_VEC = 8,
  localparam int DEPTH   = M * N + N * NUM_VEC,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          start,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [T-1:0]  data_out,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  state_t        state, state_n;
  logic [T-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr, ptr_n, rd_idx;
  logic          valid_n;
  logic          load;
  logic          present;
  logic          xfer;

`ifdef LAYER_FEEDER_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; bit 0 gates presentation of a due word.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign present = lfsr[0];
`else
  assign present = 1'b1;
`endif

  assign xfer = m_valid && m_ready;

  // NOTE: the frame array has no reset; contents must survive a reset so a
  // new start can resend the stored frame, and a resettable array is costly.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && wr_en && ({1'b0, wr_addr} < DEPTH_C))
      mem[wr_addr] <= wr_data;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = m_valid;
    load    = 1'b0;
    rd_idx  = ptr;
    case (state)
      IDLE: begin
        if (start && !wr_en) begin
          state_n = SEND;
          ptr_n   = '0;
          rd_idx  = '0;
          load    = present;
          valid_n = present;
        end
      end
      SEND: begin
        if (xfer) begin
          if (ptr == LAST_IDX) begin
            valid_n = 1'b0;
            state_n = DONE;
          end else begin
            ptr_n   = ptr + 1'b1;
            rd_idx  = ptr + 1'b1;
            load    = present;
            valid_n = present;
          end
        end else if (!m_valid && present) begin
          // A word is due but was held back by a bubble; present it now.
          load    = 1'b1;
          valid_n = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      m_valid  <= 1'b0;
      data_out <= '0;
    end else begin
      ptr     <= ptr_n;
      m_valid <= valid_n;
      if (load) data_out <= mem[rd_idx];
    end
  end

  assign m_last = m_valid && (ptr == LAST_IDX);
  assign busy   = (state == SEND);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_layer_stream_feeder.sv
// Randomized bench for layer_stream_feeder: a frame image model predicts the
// word sequence, handshake stability, m_last, done and busy.
module tb_layer_stream_feeder;

  localparam int DEPTH = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        m_ready;
  logic        m_valid;
  logic [15:0] data_out;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [15:0] ref_mem [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  layer_stream_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .data_out (data_out),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-time write; the model keeps only in-range addresses.
  task automatic write_word(input int addr, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (addr < DEPTH) ref_mem[addr] = d;
  endtask

  // Streams one frame. abort_at >= 0 asserts reset once that many words have
  // transferred; poke_at >= 0 attempts a write to word 5 mid-frame.
  task automatic run_frame(input int ready_pct, input int abort_at, input int poke_at);
    int          idx = 0;
    int          cycles = 0;
    bit          fin = 0;
    bit          poked = 0;
    logic        pv, pl, pr;
    logic [15:0] pd;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifndef LAYER_FEEDER_STALL_EN
    check("start_latency_valid", m_valid, 1);
    check("first_word", data_out, ref_mem[0]);
`endif
    while (!fin && cycles < 2000) begin
      pv = m_valid;
      pd = data_out;
      pl = m_last;
      check("busy_in_frame", busy, 1);
      if (pv) begin
        check("word", pd, ref_mem[idx]);
        check("last_flag", pl, (idx == DEPTH - 1));
      end else begin
        check("last_without_valid", pl, 0);
      end
      pr = ($urandom_range(99) < ready_pct);
      m_ready = pr;
      if (poke_at >= 0 && idx == poke_at && !poked) begin
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hFFFF; poked = 1;
      end
      if (abort_at >= 0 && idx == abort_at) reset = 1'b1;
      tick();
      wr_en = 1'b0;
      cycles++;
      if (reset) begin
        reset = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_last", m_last, 0);
        check("abort_done", done, 0);
        return;
      end
      if (pv && pr) begin
        idx++;
        if (idx == DEPTH) begin
          check("valid_after_last", m_valid, 0);
          check("done_pulse", done, 1);
          check("busy_in_done", busy, 0);
          fin = 1;
        end else begin
          check("done_early", done, 0);
        end
      end else if (pv) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", data_out, pd);
        check("stall_last_held", m_last, pl);
      end
    end
    if (!fin) begin
      check("frame_timeout", 0, 1);
    end else begin
      check("transfers", idx, DEPTH);
`ifndef LAYER_FEEDER_STALL_EN
      if (ready_pct == 100) check("back_to_back_cycles", cycles, DEPTH);
`endif
      tick();
      check("done_one_cycle", done, 0);
      check("busy_after_frame", busy, 0);
      check("valid_idle", m_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; m_ready = 1'b0;
    tick(); tick();
    check("reset_valid", m_valid, 0);
    check("reset_last", m_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", data_out, 0);
    reset = 1'b0;

    // Ramp frame, full-rate then random backpressure.
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'(i + 1));
    run_frame(100, -1, -1);
    run_frame(50, -1, -1);
    run_frame(50, -1, -1);

    // Out-of-range writes must not alias onto stored words.
    write_word(50, 16'h1234);
    write_word(63, 16'hBEEF);
    run_frame(70, -1, -1);

    // Mid-frame write ignored; the same write in idle lands.
    run_frame(100, -1, 2);
    write_word(5, 16'hFFFF);
    run_frame(100, -1, -1);

    // start with wr_en is ignored; the write itself still happens.
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'(($urandom));
    start = 1'b1;
    ref_mem[7] = wr_data;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("start_with_wr_valid", m_valid, 0);
    check("start_with_wr_busy", busy, 0);
    tick();
    check("start_with_wr_stays_idle", busy, 0);
    run_frame(100, -1, -1);

    // Random frame, reset after 20 transfers, then full resend.
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'($urandom));
    run_frame(60, 20, -1);
    run_frame(100, -1, -1);
    run_frame(30, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
